// File: rtl/cbm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbm_pkg
// Description : Shared constants, state encoding and command legality check
//               for the CBM slave register window.
// Revision    : 1.0 - initial release
// ============================================================================
package cbm_pkg;

    localparam logic [31:0] c_BASE_ADDR    = 32'h1000_FF00;
    localparam int          c_DEPTH        = 16;
    localparam logic [2:0]  c_SIZE_WORD    = 3'd2;
    localparam logic [2:0]  c_BURST_SINGLE = 3'd0;
    localparam logic [2:0]  c_BURST_INCR   = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_RBURST = 2'd2
    } cbm_state_t;

    // End address is computed in 33 bits so a high base address cannot wrap.
    function automatic logic cmd_legal(
        input logic [31:0] addr,
        input logic [10:0] length,
        input logic [2:0]  size,
        input logic [2:0]  burst
    );
        logic [32:0] w_end;
        w_end = {1'b0, addr} + {20'd0, length, 2'b00};
        cmd_legal = (size == c_SIZE_WORD) &&
                    ((burst == c_BURST_SINGLE) || (burst == c_BURST_INCR)) &&
                    (length >= 11'd1) && (length <= 11'd16) &&
                    ((burst != c_BURST_SINGLE) || (length == 11'd1)) &&
                    (addr[1:0] == 2'b00) &&
                    (addr >= c_BASE_ADDR) &&
                    (w_end <= ({1'b0, c_BASE_ADDR} + 33'd64));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbm_slave_regs_rf.sv
`default_nettype none
// ============================================================================
// Module      : cbm_slave_regs_rf
// Description : 16x32 register file, two write ports (A wins on same word),
//               one registered read port and one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cbm_slave_regs_rf
    import cbm_pkg::*;
(
    input  logic        bus1_HCLK,
    input  logic        bus1_HRESETn,
    input  logic        i_wa_en,
    input  logic [3:0]  i_wa_idx,
    input  logic [31:0] i_wa_data,
    input  logic        i_wb_en,
    input  logic [3:0]  i_wb_idx,
    input  logic [31:0] i_wb_data,
    input  logic        i_rd_en,
    input  logic [3:0]  i_rd_idx,
    output logic [31:0] o_rd_data,
    input  logic [3:0]  i_ra_idx,
    output logic [31:0] o_ra_data
);

    logic [31:0] r_mem [c_DEPTH];
    logic [31:0] r_rd_data;
    logic        w_wb_blocked;

    assign w_wb_blocked = i_wa_en && (i_wa_idx == i_wb_idx);

    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wb_en && !w_wb_blocked) begin
                r_mem[i_wb_idx] <= i_wb_data;
            end
            if (i_wa_en) begin
                r_mem[i_wa_idx] <= i_wa_data;
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_idx];
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_ra_data = r_mem[i_ra_idx];

endmodule
`default_nettype wire

// File: rtl/cbm_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : cbm_slave_regs
// Description : CBM bus slave exposing a 16-word register window with single
//               and incrementing bursts, plus a local access port.
// Revision    : 1.0 - initial release
// ============================================================================
module cbm_slave_regs
    import cbm_pkg::*;
(
    input  logic        bus1_HCLK,
    input  logic        bus1_HRESETn,
    input  logic        CBS_read_req,
    input  logic        CBS_write_req,
    input  logic [2:0]  CBS_burst,
    input  logic [31:0] CBS_addr,
    input  logic [10:0] CBS_length,
    input  logic [2:0]  CBS_size,
    input  logic        CBS_lock,
    input  logic [31:0] CBS_write_data,
    output logic [31:0] CBS_read_data,
    output logic        CBS_command_busy,
    output logic        CBS_data_ready,
    output logic        CBS_error,
    output logic [10:0] CBS_count,
    input  logic [3:0]  loc_addr,
    output logic [31:0] loc_rdata,
    input  logic        loc_we,
    input  logic [31:0] loc_wdata,
    output logic        wr_pulse
);

    cbm_state_t  r_state;
    logic [3:0]  r_ptr;
    logic [10:0] r_count;
    logic        r_busy;
    logic        r_data_ready;
    logic        r_error;
    logic        r_wr_pulse;

    logic        w_idle;
    logic        w_legal;
    logic        w_wr_cmd;
    logic        w_rd_cmd;
    logic        w_cmd_err;
    logic        w_wb_beat;
    logic        w_bus_we;
    logic [3:0]  w_bus_widx;
    logic        w_bus_re;
    logic        w_unused;

    assign w_unused  = CBS_lock;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_legal   = cmd_legal(CBS_addr, CBS_length, CBS_size, CBS_burst);
    assign w_wr_cmd  = w_idle && CBS_write_req && !CBS_read_req && w_legal;
    assign w_rd_cmd  = w_idle && CBS_read_req && !CBS_write_req && w_legal;
    assign w_cmd_err = w_idle && (CBS_read_req || CBS_write_req) && !(w_wr_cmd || w_rd_cmd);
    assign w_wb_beat = (r_state == ST_WBURST) && CBS_write_req;

    // The command cycle itself carries write beat 1.
    assign w_bus_we   = w_wr_cmd || w_wb_beat;
    assign w_bus_widx = w_wr_cmd ? CBS_addr[5:2] : r_ptr;
    assign w_bus_re   = (r_state == ST_RBURST);

    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
            r_error      <= 1'b0;
            r_wr_pulse   <= 1'b0;
        end else begin
            r_error    <= w_cmd_err;
            r_wr_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_data_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_count      <= '0;
                    if (w_wr_cmd) begin
                        if (CBS_length == 11'd1) begin
                            r_wr_pulse <= 1'b1;
                        end else begin
                            r_state <= ST_WBURST;
                            r_busy  <= 1'b1;
                            r_count <= CBS_length - 11'd1;
                            r_ptr   <= CBS_addr[5:2] + 4'd1;
                        end
                    end else if (w_rd_cmd) begin
                        r_state      <= ST_RBURST;
                        r_busy       <= 1'b1;
                        r_count      <= CBS_length;
                        r_data_ready <= 1'b0;
                        r_ptr        <= CBS_addr[5:2];
                    end
                end
                ST_WBURST: begin
                    r_data_ready <= 1'b1;
                    if (CBS_write_req) begin
                        r_ptr   <= r_ptr + 4'd1;
                        r_count <= r_count - 11'd1;
                        if (r_count == 11'd1) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_wr_pulse <= 1'b1;
                        end
                    end
                end
                ST_RBURST: begin
                    // Each edge here latches one beat out of the register file.
                    r_data_ready <= 1'b1;
                    r_ptr        <= r_ptr + 4'd1;
                    r_count      <= r_count - 11'd1;
                    if (r_count == 11'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cbm_slave_regs_rf u_rf (
        .bus1_HCLK    (bus1_HCLK),
        .bus1_HRESETn (bus1_HRESETn),
        .i_wa_en      (w_bus_we),
        .i_wa_idx     (w_bus_widx),
        .i_wa_data    (CBS_write_data),
        .i_wb_en      (loc_we),
        .i_wb_idx     (loc_addr),
        .i_wb_data    (loc_wdata),
        .i_rd_en      (w_bus_re),
        .i_rd_idx     (r_ptr),
        .o_rd_data    (CBS_read_data),
        .i_ra_idx     (loc_addr),
        .o_ra_data    (loc_rdata)
    );

    assign CBS_command_busy = r_busy;
    assign CBS_data_ready   = r_data_ready;
    assign CBS_error        = r_error;
    assign CBS_count        = r_count;
    assign wr_pulse         = r_wr_pulse;

endmodule
`default_nettype wire
